// File: rtl/dram_clk_pkg.sv
// rtl/dram_clk_pkg.sv - shared types and sizing helpers for the DRAM clock pad controller
package dram_clk_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Width of a counter that must hold 0..num_clk inclusive.
  function automatic int cnt_width(input int num_clk);
    return $clog2(num_clk + 1);
  endfunction

endpackage

// File: rtl/dram_clk_seq.sv
// rtl/dram_clk_seq.sv - staggered power-up/power-down sequencer producing per-channel requests
module dram_clk_seq
  import dram_clk_pkg::*;
#(
  parameter int NUM_CLK = 4,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               arst_l,
  input  logic               enable,
  input  logic [NUM_CLK-1:0] clk_mask,
  input  logic [GAP_W-1:0]   gap_cyc,
  output logic [NUM_CLK-1:0] req,
  output logic               stable,
  output logic               busy
);

  localparam int NW = cnt_width(NUM_CLK);
  localparam logic [NW-1:0] N_MAX = NW'(NUM_CLK);

  state_t           state, state_nx;
  logic [NW-1:0]    n, n_nx;
  logic [GAP_W-1:0] cnt, cnt_nx;

  // State, channel count and gap counter registers.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state <= IDLE;
      n     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      n     <= n_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: one channel step per gap window; a reversal keeps n so live channels never drop.
  always_comb begin
    state_nx = state;
    n_nx     = n;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (enable) begin
          n_nx     = NW'(1);
          cnt_nx   = gap_cyc;
          state_nx = (NUM_CLK == 1) ? RUN : RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (!enable) begin
          state_nx = RAMP_DOWN;
          cnt_nx   = gap_cyc;
        end else if (cnt == '0) begin
          n_nx   = n + NW'(1);
          cnt_nx = gap_cyc;
          if (n_nx == N_MAX) state_nx = RUN;
        end else begin
          cnt_nx = cnt - GAP_W'(1);
        end
      end
      RUN: begin
        if (!enable) begin
          n_nx     = N_MAX - NW'(1);
          cnt_nx   = gap_cyc;
          state_nx = (NUM_CLK == 1) ? IDLE : RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_nx = RAMP_UP;
          cnt_nx   = gap_cyc;
        end else if (cnt == '0) begin
          n_nx   = n - NW'(1);
          cnt_nx = gap_cyc;
          if (n_nx == '0) state_nx = IDLE;
        end else begin
          cnt_nx = cnt - GAP_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: status flags and the per-channel request (lowest n channels, minus masked ones).
  always_comb begin
    stable = (state == RUN);
    busy   = (state == RAMP_UP) || (state == RAMP_DOWN);
    req    = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      req[i] = (i < int'(n)) && !clk_mask[i];
    end
  end

endmodule

// File: rtl/dram_clk_pad_ctl.sv
// rtl/dram_clk_pad_ctl.sv - DRAM clock pad controller top; DRAM_CLK_SCAN_EN adds the en_q scan chain
module dram_clk_pad_ctl
  import dram_clk_pkg::*;
#(
  parameter int NUM_CLK = 4,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               arst_l,
  input  logic               testmode_l,
  input  logic               dram_io_clk_enable,
  input  logic               clk_value,
  input  logic [NUM_CLK-1:0] clk_mask,
  input  logic [GAP_W-1:0]   gap_cyc,
  input  logic               clk_pad_clk_si,
  input  logic               clk_pad_clk_se,
  output logic               clk_pad_clk_so,
  output logic [NUM_CLK-1:0] to_pad,
  output logic [NUM_CLK-1:0] clk_en_q,
  output logic               clk_stable,
  output logic               clk_busy
);

  logic [NUM_CLK-1:0] req;
  logic [NUM_CLK-1:0] en_q;
  logic [NUM_CLK-1:0] clk_out;
  logic               tclk;

  dram_clk_seq #(
    .NUM_CLK (NUM_CLK),
    .GAP_W   (GAP_W)
  ) u_seq (
    .clk      (clk),
    .arst_l   (arst_l),
    .enable   (dram_io_clk_enable),
    .clk_mask (clk_mask),
    .gap_cyc  (gap_cyc),
    .req      (req),
    .stable   (clk_stable),
    .busy     (clk_busy)
  );

  // Functional mode captures on the falling edge, half a cycle after the sequencer moves.
  assign tclk = testmode_l ? ~clk : clk;

`ifdef DRAM_CLK_SCAN_EN
  // Enable flops with scan shift si -> en_q[0] -> ... -> en_q[NUM_CLK-1] -> so.
  always_ff @(posedge tclk or negedge arst_l) begin
    if (!arst_l) begin
      en_q <= '0;
    end else if (clk_pad_clk_se) begin
      en_q <= NUM_CLK'({en_q, clk_pad_clk_si});
    end else begin
      en_q <= req;
    end
  end

  assign clk_pad_clk_so = en_q[NUM_CLK-1];
`else
  // Enable flops, functional capture only.
  always_ff @(posedge tclk or negedge arst_l) begin
    if (!arst_l) begin
      en_q <= '0;
    end else begin
      en_q <= req;
    end
  end

  logic unused_scan;
  assign unused_scan    = clk_pad_clk_si ^ clk_pad_clk_se;
  assign clk_pad_clk_so = 1'b0;
`endif

  assign clk_out  = {NUM_CLK{clk_value}} & en_q;
  assign clk_en_q = en_q;

  // Pad mux: an enabled channel inverts in the low phase so the pad follows clk.
  always_comb begin
    to_pad = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      to_pad[i] = clk ? clk_out[i] : (en_q[i] ? ~clk_out[i] : clk_out[i]);
    end
  end

endmodule

// File: tb/tb_dram_clk_pad_ctl.sv
// tb/tb_dram_clk_pad_ctl.sv - randomized scoreboard bench for dram_clk_pad_ctl
module tb_dram_clk_pad_ctl;

  localparam int NUM  = 4;
  localparam int NCYC = 3000;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_RUN  = 2;
  localparam int M_DOWN = 3;

  logic           clk = 1'b0;
  logic           arst_l;
  logic           testmode_l;
  logic           dram_io_clk_enable;
  logic           clk_value;
  logic [NUM-1:0] clk_mask;
  logic [3:0]     gap_cyc;
  logic           clk_pad_clk_si;
  logic           clk_pad_clk_se;
  logic           clk_pad_clk_so;
  logic [NUM-1:0] to_pad;
  logic [NUM-1:0] clk_en_q;
  logic           clk_stable;
  logic           clk_busy;

  dram_clk_pad_ctl #(.NUM_CLK(NUM), .GAP_W(4)) dut (
    .clk                (clk),
    .arst_l             (arst_l),
    .testmode_l         (testmode_l),
    .dram_io_clk_enable (dram_io_clk_enable),
    .clk_value          (clk_value),
    .clk_mask           (clk_mask),
    .gap_cyc            (gap_cyc),
    .clk_pad_clk_si     (clk_pad_clk_si),
    .clk_pad_clk_se     (clk_pad_clk_se),
    .clk_pad_clk_so     (clk_pad_clk_so),
    .to_pad             (to_pad),
    .clk_en_q           (clk_en_q),
    .clk_stable         (clk_stable),
    .clk_busy           (clk_busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit             stable;
    bit             busy;
    logic [NUM-1:0] pad_hi;
    logic [NUM-1:0] en;
    logic [NUM-1:0] pad_lo;
  } item_t;

  item_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  bit drv_done    = 0;

  // reference model: phase of the ramp, channels requested, cycles until the next step
  int             m_phase;
  int             m_n;
  int             m_wait;
  logic [NUM-1:0] m_en;
  int             resets_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_n     = 0;
    m_wait  = 0;
    m_en    = '0;
  endtask

  // One sequencer edge: a step happens when the waiting time has run out; direction follows the request.
  task automatic model_edge(input bit want_on, input int gap);
    if (m_phase == M_IDLE) begin
      if (want_on) begin
        m_n     = 1;
        m_wait  = gap;
        m_phase = (m_n == NUM) ? M_RUN : M_UP;
      end
    end else if (m_phase == M_RUN) begin
      if (!want_on) begin
        m_n     = NUM - 1;
        m_wait  = gap;
        m_phase = (m_n == 0) ? M_IDLE : M_DOWN;
      end
    end else begin
      bit going_up;
      going_up = (m_phase == M_UP);
      if (want_on != going_up) begin
        m_phase = want_on ? M_UP : M_DOWN;
        m_wait  = gap;
      end else if (m_wait > 0) begin
        m_wait = m_wait - 1;
      end else begin
        m_n    = going_up ? m_n + 1 : m_n - 1;
        m_wait = gap;
        if (m_n == NUM) m_phase = M_RUN;
        if (m_n == 0)   m_phase = M_IDLE;
      end
    end
  endtask

  function automatic logic [NUM-1:0] requested(input int n, input logic [NUM-1:0] mask);
    logic [NUM-1:0] r;
    for (int i = 0; i < NUM; i++) r[i] = (i < n) && !mask[i];
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, " clk_en_q"}, clk_en_q, 0);
    chk({tag, " to_pad"}, to_pad, 0);
    chk({tag, " clk_stable"}, clk_stable, 0);
    chk({tag, " clk_busy"}, clk_busy, 0);
    chk({tag, " so"}, clk_pad_clk_so, 0);
  endtask

  // Stimulus: inputs change just after the falling edge, model advances before the next rising edge.
  task automatic driver();
    item_t it;
    logic [NUM-1:0] cvv;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      #2;
      if ($urandom_range(0, 23) == 0) dram_io_clk_enable = ~dram_io_clk_enable;
      if ($urandom_range(0, 15) == 0) gap_cyc = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) clk_mask = ($urandom_range(0, 1) == 0) ? '0 : NUM'($urandom);
      clk_value      = ($urandom_range(0, 9) != 0);
      clk_pad_clk_si = 1'($urandom);
      if (m_phase == M_UP && m_n == 3 && resets_done < 4 && $urandom_range(0, 1) == 0) begin
        dram_io_clk_enable = 1'b1;
        arst_l = 1'b0;
        #1;
        check_all_zero("async reset");
        arst_l = 1'b1;
        resets_done++;
        model_reset();
      end else begin
        #1;
      end
      #1;
      cvv       = {NUM{clk_value}};
      it.pad_hi = m_en & cvv;
      model_edge(dram_io_clk_enable, int'(gap_cyc));
      m_en      = requested(m_n, clk_mask);
      it.en     = m_en;
      it.pad_lo = m_en & ~cvv;
      it.stable = (m_phase == M_RUN);
      it.busy   = (m_phase == M_UP) || (m_phase == M_DOWN);
      sb.push_back(it);
    end
    drv_done = 1;
  endtask

  // Monitor: status and high-phase pads after the rising edge, enables and low-phase pads after the falling edge.
  task automatic monitor();
    item_t it;
    for (int c = 0; c < NCYC + 50; c++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        if (drv_done) break;
        continue;
      end
      it = sb.pop_front();
      chk("clk_stable", clk_stable, it.stable);
      chk("clk_busy", clk_busy, it.busy);
      chk("to_pad high phase", to_pad, it.pad_hi);
      @(negedge clk);
      #1;
      chk("clk_en_q", clk_en_q, it.en);
      chk("to_pad low phase", to_pad, it.pad_lo);
    end
    chk("scoreboard drained", sb.size(), 0);
  endtask

  initial begin
    logic [3:0] pat;
    logic       exp_so;
    arst_l             = 1'b0;
    testmode_l         = 1'b1;
    dram_io_clk_enable = 1'b0;
    clk_value          = 1'b1;
    clk_mask           = '0;
    gap_cyc            = 4'd2;
    clk_pad_clk_si     = 1'b0;
    clk_pad_clk_se     = 1'b0;
    resets_done        = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset high phase");
    @(negedge clk);
    #1;
    check_all_zero("reset low phase");
    #1;
    arst_l = 1'b1;

    fork
      driver();
      monitor();
    join

    // Scan phase: test-mode clocking, shift a pattern through the enable flops.
    @(negedge clk);
    #1;
    arst_l             = 1'b0;
    dram_io_clk_enable = 1'b0;
    testmode_l         = 1'b0;
    clk_pad_clk_se     = 1'b1;
    #1;
    arst_l = 1'b1;
    pat    = 4'b1101;
    for (int k = 0; k < 7; k++) begin
      clk_pad_clk_si = (k < 4) ? pat[3 - k] : 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      if (k >= 3) begin
`ifdef DRAM_CLK_SCAN_EN
        exp_so = pat[6 - k];
`else
        exp_so = 1'b0;
`endif
        chk("scan so", clk_pad_clk_so, exp_so);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
